// File: rtl/sub_pkg.sv
// Shared types and elaboration-time checks for the serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    // Legal configurations: 1 <= digit <= width and digit divides width evenly.
    function automatic bit params_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_subtractor.sv
// DIGIT-bit ripple-borrow subtractor: {bo, d} = x - y - bi.
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo,
    output logic             bmsb
);

    logic [DIGIT:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bi;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]    = x[i] ^ y[i] ^ br[i];
            br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
        end
    end

    assign bo   = br[DIGIT];
    assign bmsb = br[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, DIGIT bits per clock, LSB digit first, with
// valid/ready handshakes and registered borrow/zero/overflow flags.
//
//  state | meaning
//  IDLE  | in_ready high; waiting for operands
//  RUN   | one digit per clock, S clocks
//  DONE  | out_valid high; result held until out_ready
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int S  = WIDTH / DIGIT;
    localparam int CW = $clog2(S + 1);
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_subtractor: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_d;
    logic             dig_bo, dig_bmsb;
    logic [WIDTH-1:0] a_shift, b_shift;

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .bi   (br_q),
        .d    (dig_d),
        .bo   (dig_bo),
        .bmsb (dig_bmsb)
    );

    // The digits vacated at the top of a_q collect the result, so after S
    // steps a_shift holds the complete difference.
    if (S == 1) begin : g_single
        assign a_shift = dig_d;
        assign b_shift = '0;
    end else begin : g_multi
        assign a_shift = {dig_d, a_q[WIDTH-1:DIGIT]};
        assign b_shift = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_shift;
                b_d   = b_shift;
                br_d  = dig_bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = a_shift;
                    bout_d  = dig_bo;
                    zero_d  = (a_shift == '0);
                    ovf_d   = dig_bmsb ^ dig_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: four DIGIT configurations run in parallel against an
// integer-arithmetic reference model.
module tb_serial_subtractor;

    localparam int W     = 16;
    localparam int NCFG  = 4;
    localparam int NRAND = 1000;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int finished = 0;

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin);
        exp_t e;
        int   r;
        int   sr;
        r      = int'(ma) - int'(mb) - int'(mbin);
        sr     = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        e.diff = r[W-1:0];
        e.bout = (r < 0);
        e.ovf  = (sr > 32767) || (sr < -32768);
        e.zero = (e.diff == '0);
        e.acc  = 0;
        return e;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16;
        localparam int S  = W / DG;

        logic         rst       = 1'b0;
        logic         in_valid  = 1'b0;
        logic         out_ready = 1'b1;
        logic         bin       = 1'b0;
        logic [W-1:0] a         = '0;
        logic [W-1:0] b         = '0;
        logic         in_ready, out_valid, bout, zero, ovf;
        logic [W-1:0] diff;

        exp_t q[$];
        exp_t cur;
        bit   have_cur = 1'b0;
        int   cyc = 0;

        serial_subtractor #(.WIDTH(W), .DIGIT(DG)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .bin       (bin),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .diff      (diff),
            .bout      (bout),
            .zero      (zero),
            .ovf       (ovf)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: pops on the first DONE cycle, then checks every DONE cycle
        // for stability until the handshake completes.
        initial forever begin
            @(negedge clk);
            if (rst) begin
                have_cur = 1'b0;
            end else if (out_valid) begin
                if (!have_cur) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL d%0d unexpected_result: got diff=%h, expected no result", DG, diff);
                    end else begin
                        cur      = q.pop_front();
                        have_cur = 1'b1;
                        checks++;
                        if (cyc - cur.acc != S) begin
                            errors++;
                            $display("FAIL d%0d latency: got %0d cycles, expected %0d", DG, cyc - cur.acc, S);
                        end
                    end
                end
                if (have_cur) begin
                    checks++;
                    if ({diff, bout, zero, ovf} !== {cur.diff, cur.bout, cur.zero, cur.ovf}) begin
                        errors++;
                        $display("FAIL d%0d result: got diff=%h bout=%b zero=%b ovf=%b, expected diff=%h bout=%b zero=%b ovf=%b",
                                 DG, diff, bout, zero, ovf, cur.diff, cur.bout, cur.zero, cur.ovf);
                    end
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL d%0d in_ready_in_done: got %b, expected 0", DG, in_ready);
                    end
                    if (out_ready) have_cur = 1'b0;
                end
            end
        end

        task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
            int   n;
            exp_t e;
            n = 0;
            while (in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL d%0d issue_timeout: in_ready=%b, expected 1", DG, in_ready);
            end
            a        = ta;
            b        = tb_v;
            bin      = tbin;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            e     = model(ta, tb_v, tbin);
            e.acc = cyc;
            q.push_back(e);
            in_valid = 1'b0;
            a        = 16'($urandom);
            b        = 16'($urandom);
            bin      = 1'($urandom);
        endtask

        task automatic check_reset_outputs(input string tag);
            checks++;
            if ({out_valid, in_ready, diff, bout, zero, ovf} !== {1'b0, 1'b1, 16'h0000, 3'b000}) begin
                errors++;
                $display("FAIL d%0d %s: got out_valid=%b in_ready=%b diff=%h bout=%b zero=%b ovf=%b, expected 0 1 0000 0 0 0",
                         DG, tag, out_valid, in_ready, diff, bout, zero, ovf);
            end
        endtask

        initial begin
            int n;
            #2 rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check_reset_outputs("reset_state");
            #2 rst = 1'b0;

            issue(16'h1234, 16'h0234, 1'b0);
            issue(16'h0000, 16'h0001, 1'b0);
            issue(16'h8000, 16'h0001, 1'b0);
            issue(16'h0005, 16'h0004, 1'b1);

            // Backpressure: hold the result while offering new operands.
            n = 0;
            while (in_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            out_ready = 1'b0;
            issue(16'h7FFF, 16'hFFFF, 1'b1);
            n = 0;
            while (out_valid !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                in_valid = 1'b1;
                a        = 16'($urandom);
                b        = 16'($urandom);
                bin      = 1'($urandom);
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL d%0d backpressure_hold: got out_valid=%b in_ready=%b, expected 1 0",
                             DG, out_valid, in_ready);
                end
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            issue(16'hC350, 16'h3A98, 1'b0);

            // Reset one cycle into RUN discards the in-flight operation.
            issue(16'hABCD, 16'h1234, 1'b0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check_reset_outputs("reset_mid_op");
            q.delete();
            @(posedge clk);
            #3 rst = 1'b0;
            issue(16'h00FF, 16'h000F, 1'b0);

            for (int i = 0; i < NRAND; i++) begin
                issue(16'($urandom), 16'($urandom), 1'($urandom));
            end

            n = 0;
            while ((q.size() != 0 || have_cur) && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (q.size() != 0 || have_cur) begin
                errors++;
                $display("FAIL d%0d drain: %0d results outstanding, expected 0", DG, q.size());
            end
            finished++;
        end
    end

    initial begin
        int n;
        n = 0;
        while (finished < NCFG && n < 90000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (finished < NCFG) begin
            errors++;
            $display("FAIL global_timeout: %0d configurations finished, expected %0d", finished, NCFG);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
